// File: rtl/rv32_mem_pkg.sv
// Shared constants for the rv32im_zbb MEM stage.
// Load/store width codes, FSM encoding and counter sizing.
package rv32_mem_pkg;

  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane select/extension for loads.
// Also flags misaligned addresses and width codes illegal for the op.
module load_store_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] sh;

  assign sh = ld_raw >> {addr_lo, 3'b000};

  always_comb begin
    be         = '0;
    wdata      = '0;
    ld_data    = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    unique case (funct3)
      F3_LB: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sh[7]}}, sh[7:0]};
      end
      F3_LH: begin
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        wdata      = {2{st_data[15:0]}};
        ld_data    = {{16{sh[15]}}, sh[15:0]};
      end
      F3_LW: begin
        misaligned = |addr_lo;
        be         = 4'b1111;
        wdata      = st_data;
        ld_data    = ld_raw;
      end
      F3_LBU: begin
        illegal = is_store;
        be      = 4'b0001 << addr_lo;
        ld_data = {24'd0, sh[7:0]};
      end
      F3_LHU: begin
        illegal    = is_store;
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        ld_data    = {16'd0, sh[15:0]};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_phase.sv
// MEM stage: EX/MEM register, data-memory req/ack FSM with timeout,
// and the MEM/WB result used for writeback and forwarding.
module memory_phase
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_25mhz,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_wr_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] ex_mem_o,
  output logic [31:0] mem_wb_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_reg_wr_o,
  output logic        err_o
);

  localparam int CW = cnt_width(TIMEOUT);

  mem_state_e  state;
  logic [CW-1:0] cnt;

  logic        ex_valid;
  logic [31:0] ex_addr;
  logic [31:0] ex_rs2;
  logic [2:0]  ex_f3;
  logic        ex_mrd;
  logic        ex_mwr;
  logic [4:0]  ex_rd;
  logic        ex_regwr;

  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld_data;
  logic        misaligned;
  logic        illegal;

  logic mem_op;
  logic bad;
  logic go;
  logic in_wait;
  logic terminal;

  load_store_align u_align (
    .addr_lo    (ex_addr[1:0]),
    .funct3     (ex_f3),
    .is_store   (ex_mwr),
    .st_data    (ex_rs2),
    .ld_raw     (dmem_rdata_i),
    .be         (be),
    .wdata      (wdata),
    .ld_data    (ld_data),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign mem_op   = ex_valid & (ex_mrd | ex_mwr);
  assign bad      = misaligned | illegal;
  assign in_wait  = (state == S_WAIT);
  assign go       = (state == S_IDLE) & mem_op & ~bad;
  assign terminal = (cnt == CW'(TIMEOUT - 1));

  // Abort cycle also releases the stall so the timed-out op is not re-issued.
  assign stall_o    = go | (in_wait & ~dmem_ack_i & ~terminal);
  assign dmem_req_o = go | in_wait;
  assign dmem_we_o  = dmem_req_o & ex_mwr;

  assign dmem_addr_o  = dmem_req_o ? {ex_addr[31:2], 2'b00} : 32'd0;
  assign dmem_be_o    = dmem_req_o ? be : 4'd0;
  assign dmem_wdata_o = dmem_we_o ? wdata : 32'd0;
  assign ex_mem_o     = ex_addr;

  always_ff @(posedge clk_25mhz) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ex_valid    <= 1'b0;
      ex_addr     <= '0;
      ex_rs2      <= '0;
      ex_f3       <= '0;
      ex_mrd      <= 1'b0;
      ex_mwr      <= 1'b0;
      ex_rd       <= '0;
      ex_regwr    <= 1'b0;
      mem_wb_o    <= '0;
      wb_rd_o     <= '0;
      wb_reg_wr_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (!stall_o) begin
        ex_valid <= valid_i;
        ex_addr  <= alu_res_i;
        ex_rs2   <= rs2_i;
        ex_f3    <= funct3_i;
        ex_mrd   <= mem_rd_i;
        ex_mwr   <= mem_wr_i;
        ex_rd    <= rd_i;
        ex_regwr <= reg_wr_i;
      end
      wb_reg_wr_o <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (ex_valid) begin
            if (!mem_op) begin
              mem_wb_o    <= ex_addr;
              wb_rd_o     <= ex_rd;
              wb_reg_wr_o <= ex_regwr;
            end else if (bad) begin
              err_o <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_ack_i) begin
            if (!ex_mwr) begin
              mem_wb_o    <= ld_data;
              wb_rd_o     <= ex_rd;
              wb_reg_wr_o <= ex_regwr;
            end
            state <= S_IDLE;
            cnt   <= '0;
          end else if (terminal) begin
            err_o <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
